// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bundle: upstream payload and controls into the stage register, registered payload and counters out.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 161,
  parameter int CNT_W  = 16
);
  logic              In_Valid;
  logic [CTRL_W-1:0] In_Ctrl;
  logic [DATA_W-1:0] In_Data;
  logic              Stall;
  logic              Flush;
  logic              Cnt_Clear;
  logic              Out_Valid;
  logic [CTRL_W-1:0] Out_Ctrl;
  logic [DATA_W-1:0] Out_Data;
  logic [CNT_W-1:0]  Stall_Cnt;
  logic [CNT_W-1:0]  Flush_Cnt;

  modport master (
    output In_Valid, In_Ctrl, In_Data, Stall, Flush, Cnt_Clear,
    input  Out_Valid, Out_Ctrl, Out_Data, Stall_Cnt, Flush_Cnt
  );

  modport slave (
    input  In_Valid, In_Ctrl, In_Data, Stall, Flush, Cnt_Clear,
    output Out_Valid, Out_Ctrl, Out_Data, Stall_Cnt, Flush_Cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid, stall-hold and flush-to-bubble; 1-cycle latency, all outputs registered.
// Optional saturating stall/flush counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int                CTRL_W    = 9,
  parameter int                DATA_W    = 161,
  parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}},
  parameter int                CNT_W     = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  pipe_stage_reg_if.slave bus
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Priority Flush > Stall > Load; a bubble never keeps a KILL_MASK bit set.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (bus.Flush) begin
      valid_d = 1'b0;
      ctrl_d  = ctrl_q & ~KILL_MASK;
    end else if (!bus.Stall) begin
      valid_d = bus.In_Valid;
      ctrl_d  = bus.In_Valid ? bus.In_Ctrl : (bus.In_Ctrl & ~KILL_MASK);
      data_d  = bus.In_Data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign bus.Out_Valid = valid_q;
  assign bus.Out_Ctrl  = ctrl_q;
  assign bus.Out_Data  = data_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Only occupied stages count; Flush masks a simultaneous Stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.Cnt_Clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else if (valid_q) begin
      if (bus.Flush && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_d = flush_cnt_q + 1'b1;
      else if (!bus.Flush && bus.Stall && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.Stall_Cnt = stall_cnt_q;
  assign bus.Flush_Cnt = flush_cnt_q;
`else
  assign bus.Stall_Cnt = '0;
  assign bus.Flush_Cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a default instance and a narrow-counter/partial-mask instance with shared stimulus, checked against a rule-level model.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         rst;
  logic         in_valid, stall, flush, clr;
  logic [8:0]   in_ctrl;
  logic [160:0] in_data;

  int vectors    = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  pipe_stage_reg_if #(.CTRL_W(9), .DATA_W(161), .CNT_W(16)) bus_a ();
  pipe_stage_reg_if #(.CTRL_W(9), .DATA_W(161), .CNT_W(4))  bus_b ();

  assign bus_a.In_Valid  = in_valid;
  assign bus_a.In_Ctrl   = in_ctrl;
  assign bus_a.In_Data   = in_data;
  assign bus_a.Stall     = stall;
  assign bus_a.Flush     = flush;
  assign bus_a.Cnt_Clear = clr;
  assign bus_b.In_Valid  = in_valid;
  assign bus_b.In_Ctrl   = in_ctrl;
  assign bus_b.In_Data   = in_data;
  assign bus_b.Stall     = stall;
  assign bus_b.Flush     = flush;
  assign bus_b.Cnt_Clear = clr;

  pipe_stage_reg #(.CTRL_W(9), .DATA_W(161), .CNT_W(16)) dut_a (
    .Clk   (Clk),
    .Reset (rst),
    .bus   (bus_a.slave)
  );

  pipe_stage_reg #(.CTRL_W(9), .DATA_W(161), .KILL_MASK(9'h00F), .CNT_W(4)) dut_b (
    .Clk   (Clk),
    .Reset (rst),
    .bus   (bus_b.slave)
  );

  typedef struct {
    logic         v;
    logic [8:0]   c;
    logic [160:0] d;
    int           sc;
    int           fc;
  } mdl_t;

  mdl_t ma, mb;

  // Next expected contents of one stage from this cycle's inputs.
  function automatic mdl_t mstep(mdl_t m, logic [8:0] mask, int cmax);
    mdl_t n = m;
    if (rst) begin
      n.v = 1'b0; n.c = '0; n.d = '0; n.sc = 0; n.fc = 0;
      return n;
    end
    if (clr) begin
      n.sc = 0; n.fc = 0;
    end else if (m.v && flush) begin
      n.fc = (m.fc < cmax) ? m.fc + 1 : cmax;
    end else if (m.v && stall) begin
      n.sc = (m.sc < cmax) ? m.sc + 1 : cmax;
    end
    if (flush) begin
      n.v = 1'b0;
      n.c = m.c & ~mask;
    end else if (!stall) begin
      n.v = in_valid;
      n.c = in_valid ? in_ctrl : (in_ctrl & ~mask);
      n.d = in_data;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("a_valid", bus_a.Out_Valid, ma.v);
    chk("a_ctrl",  bus_a.Out_Ctrl,  ma.c);
    chk("a_data",  bus_a.Out_Data,  ma.d);
    chk("a_scnt",  bus_a.Stall_Cnt, PERF ? ma.sc : 0);
    chk("a_fcnt",  bus_a.Flush_Cnt, PERF ? ma.fc : 0);
    chk("b_valid", bus_b.Out_Valid, mb.v);
    chk("b_ctrl",  bus_b.Out_Ctrl,  mb.c);
    chk("b_data",  bus_b.Out_Data,  mb.d);
    chk("b_scnt",  bus_b.Stall_Cnt, PERF ? mb.sc : 0);
    chk("b_fcnt",  bus_b.Flush_Cnt, PERF ? mb.fc : 0);
  endtask

  task automatic tick();
    @(posedge Clk);
    ma = mstep(ma, 9'h1FF, 65535);
    mb = mstep(mb, 9'h00F, 15);
    #1;
    chk_all();
  endtask

  function automatic logic [160:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    ma = '{v: 1'b0, c: '0, d: '0, sc: 0, fc: 0};
    mb = ma;
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    stall = 1'b0; flush = 1'b0; clr = 1'b0;

    // Reset for two cycles: everything reads zero.
    tick();
    tick();
    chk("rst_valid", bus_a.Out_Valid, 1'b0);
    chk("rst_data",  bus_a.Out_Data,  '0);

    // First edge after reset loads.
    rst = 1'b0; in_valid = 1'b1; in_ctrl = 9'h1A5;
    in_data = rnd_data(); in_data[31:0] = 32'hDEADBEEF;
    tick();
    chk("load_valid", bus_a.Out_Valid, 1'b1);
    chk("load_ctrl",  bus_a.Out_Ctrl,  9'h1A5);
    chk("load_low",   bus_a.Out_Data[31:0], 32'hDEADBEEF);

    // Stall holds for N+1 cycles while input changes.
    in_data = '0; in_data[31:0] = 32'h00000004;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = rnd_data();
      tick();
      chk("stall_hold", bus_a.Out_Data[31:0], 32'h00000004);
    end
    chk("stall_cnt3", bus_a.Stall_Cnt, PERF ? 16'd3 : 16'd0);

    // Flush a valid entry, then flush the empty stage.
    stall = 1'b0; in_valid = 1'b1; in_ctrl = 9'h1FF; in_data = rnd_data();
    tick();
    flush = 1'b1;
    tick();
    chk("flush_valid", bus_a.Out_Valid, 1'b0);
    chk("flush_ctrl",  bus_a.Out_Ctrl,  9'h000);
    chk("flush_ctrlb", bus_b.Out_Ctrl,  9'h1F0);
    chk("flush_data",  bus_a.Out_Data,  in_data);
    chk("flush_cnt1",  bus_a.Flush_Cnt, PERF ? 16'd1 : 16'd0);
    tick();
    chk("flush_empty", bus_a.Flush_Cnt, PERF ? 16'd1 : 16'd0);

    // Stall and Flush together on a valid entry.
    flush = 1'b0; in_ctrl = 9'h0A3;
    tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    chk("sf_valid", bus_a.Out_Valid, 1'b0);
    chk("sf_scnt",  bus_a.Stall_Cnt, PERF ? 16'd3 : 16'd0);
    chk("sf_fcnt",  bus_a.Flush_Cnt, PERF ? 16'd2 : 16'd0);

    // Invalid load with the partial mask.
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = 9'h1FF;
    tick();
    chk("inv_ctrlb",  bus_b.Out_Ctrl,  9'h1F0);
    chk("inv_validb", bus_b.Out_Valid, 1'b0);

    // Saturation of the 4-bit counter, then clear while stalling.
    in_valid = 1'b1; in_ctrl = 9'h055;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_b", bus_b.Stall_Cnt, PERF ? 4'd15 : 4'd0);
    clr = 1'b1;
    tick();
    chk("clr_b", bus_b.Stall_Cnt, 4'd0);
    chk("clr_hold_valid", bus_b.Out_Valid, 1'b1);
    clr = 1'b0;

    // Reset in the middle of a stall.
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_scnt", bus_a.Stall_Cnt, 16'd0);
    rst = 1'b0; stall = 1'b0;

    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      stall    = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 6) == 0);
      clr      = ($urandom_range(0, 24) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_ctrl  = 9'($urandom);
      in_data  = rnd_data();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
